calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, meaning operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port data_in, input, WIDTH bits: operand value from the switches.
REQ-005 The block SHALL have port op_in, input, 2 bits: operation select, 0=add, 1=sub, 2=and, 3=or.
REQ-006 The block SHALL have port enter, input, 1 bit: confirm button, synchronous, debounced level.
REQ-007 The block SHALL have port undo, input, 1 bit: step-back button, synchronous, debounced level.
REQ-008 The block SHALL have port alu_result, input, WIDTH bits: combinational result from the ALU.
REQ-009 The block SHALL have port alu_error, input, 1 bit: ALU carry-out flag.
REQ-010 The block SHALL have ports alu_a and alu_b, output, WIDTH bits each: registered operands to the ALU.
REQ-011 The block SHALL have port alu_op, output, 2 bits: registered operation to the ALU.
REQ-012 The block SHALL have port display, output, WIDTH bits: value for the 7-segment driver.
REQ-013 The block SHALL have port state_o, output, 3 bits: current state encoding.
REQ-014 The block SHALL have port result_valid, output, 1 bit: high while a captured result is shown.
REQ-015 The block SHALL have port error_o, output, 1 bit: high while the shown result carries an error.

Function
REQ-016 A press SHALL be the rising edge of enter (enter=1, enter_q=0); an undo press SHALL be the rising edge of undo; a held button SHALL produce exactly one press.
REQ-017 The FSM SHALL have these states: S_A=0, S_B=1, S_OP=2, S_CALC=3, S_RES=4.
REQ-018 In S_A, display SHALL equal data_in (live); a press SHALL latch alu_a<=data_in and move to S_B.
REQ-019 In S_B, display SHALL equal data_in; a press SHALL latch alu_b<=data_in and move to S_OP.
REQ-020 In S_OP, display SHALL equal zero-extended op_in; a press SHALL latch alu_op<=op_in and move to S_CALC.
REQ-021 S_CALC SHALL last exactly one cycle; it SHALL capture result_reg<=alu_result and err_reg<=alu_error, set result_valid, and move to S_RES. The latency from the S_OP press edge to result_valid=1 SHALL be 2 edges.
REQ-022 In S_RES, display SHALL equal result_reg and error_o SHALL equal err_reg.
REQ-023 A press in S_RES with err_reg=0 SHALL chain: alu_a<=result_reg, clear result_valid, move to S_B.
REQ-024 A press in S_RES with err_reg=1 SHALL clear result_valid and err_reg and move to S_A.
REQ-025 An undo press SHALL step back one state: S_B->S_A, S_OP->S_B, S_RES->S_A (clearing result_valid and err_reg); in S_A it SHALL have no effect.
REQ-026 Both press types SHALL be ignored in S_CALC, with no edge lost or queued.
REQ-027 If enter and undo presses occur in the same cycle, undo SHALL win.
REQ-028 Undo SHALL NOT modify alu_a, alu_b or alu_op; previously latched values persist until overwritten.
REQ-029 Unused state encodings 5-7 SHALL return to S_A on the next edge.

Reset
REQ-030 On rst_n=0, regardless of clk, the block SHALL immediately clear: state=S_A; alu_a, alu_b, alu_op, result_reg, err_reg = 0; result_valid=0; error_o=0; enter_q=0; undo_q=0.
REQ-031 A reset asserted mid-sequence, including during S_CALC, SHALL abandon the operation with no capture.
REQ-032 A button held high across reset release SHALL NOT generate a press until it is released and pressed again.

Structure
REQ-033 Package calc_pkg SHALL hold: the state enum, the WIDTH default, and the op constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, shared with the ALU.
REQ-034 Rising-edge detection SHALL be one sub-module, edge_detect, instantiated twice (enter and undo).
REQ-035 The ALU SHALL stay outside this block and connect at the top level.

Verification
REQ-036 The bench SHALL cover: A=5, B=3, op=0 -> S_RES, display=0x0008, error_o=0, result_valid 2 edges after the op press.
REQ-037 The bench SHALL cover: A=0xFFFF, B=0x0001, op=0 -> display=0x0000, error_o=1; next press -> S_A with error_o=0.
REQ-038 The bench SHALL cover chaining: 0x00F0 or 0x000F = 0x00FF; press; B=0x0F0F, op=2 -> display=0x000F.
REQ-039 The bench SHALL cover undo: in S_OP undo -> S_B, alu_b unchanged; enter and undo in the same cycle in S_B -> S_A.
REQ-040 The bench SHALL cover held enter for 10 cycles in S_A -> exactly one transition to S_B.
REQ-041 The bench SHALL cover rst_n pulsed low during S_CALC -> all outputs 0, state_o=0, with no capture.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer and its external ALU.
package calc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned OP_W          = 2;
    localparam int unsigned STATE_W       = 3;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_AND = 2'd2;
    localparam logic [OP_W-1:0] OP_OR  = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// Single-pulse rising-edge detector for a debounced button level.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_press_c
);

    logic r_q;
    logic r_armed;

    // Armed only after the level has been seen low, so a button held through reset stays silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_q     <= i_level;
            r_armed <= r_armed | ~i_level;
        end
    end

    assign o_press_c = i_level & ~r_q & r_armed;

endmodule

// File: rtl/calc_sequencer.sv
// Operand/operation entry sequencer driving an external ALU and a 7-segment display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [OP_W-1:0]    op_in,
    input  logic               enter,
    input  logic               undo,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_error,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OP_W-1:0]    alu_op,
    output logic [WIDTH-1:0]   display,
    output logic [STATE_W-1:0] state_o,
    output logic               result_valid,
    output logic               error_o
);

    logic w_enter;
    logic w_undo;

    edge_detect u_enter_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_level   (enter),
        .o_press_c (w_enter)
    );

    edge_detect u_undo_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_level   (undo),
        .o_press_c (w_undo)
    );

    state_e            r_state,  w_state_nxt;
    logic [WIDTH-1:0]  r_alu_a,  w_alu_a_nxt;
    logic [WIDTH-1:0]  r_alu_b,  w_alu_b_nxt;
    logic [OP_W-1:0]   r_alu_op, w_alu_op_nxt;
    logic [WIDTH-1:0]  r_result, w_result_nxt;
    logic              r_err,    w_err_nxt;
    logic              r_valid,  w_valid_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_alu_a  <= w_alu_a_nxt;
            r_alu_b  <= w_alu_b_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    // Undo is tested first in every state so it wins over a simultaneous enter.
    always_comb begin
        w_state_nxt  = r_state;
        w_alu_a_nxt  = r_alu_a;
        w_alu_b_nxt  = r_alu_b;
        w_alu_op_nxt = r_alu_op;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        w_valid_nxt  = r_valid;
        case (r_state)
            S_A: begin
                if (!w_undo && w_enter) begin
                    w_alu_a_nxt = data_in;
                    w_state_nxt = S_B;
                end
            end
            S_B: begin
                if (w_undo) begin
                    w_state_nxt = S_A;
                end else if (w_enter) begin
                    w_alu_b_nxt = data_in;
                    w_state_nxt = S_OP;
                end
            end
            S_OP: begin
                if (w_undo) begin
                    w_state_nxt = S_B;
                end else if (w_enter) begin
                    w_alu_op_nxt = op_in;
                    w_state_nxt  = S_CALC;
                end
            end
            S_CALC: begin
                w_result_nxt = alu_result;
                w_err_nxt    = alu_error;
                w_valid_nxt  = 1'b1;
                w_state_nxt  = S_RES;
            end
            S_RES: begin
                if (w_undo || (w_enter && r_err)) begin
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_A;
                end else if (w_enter) begin
                    w_alu_a_nxt = r_result;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_B;
                end
            end
            default: begin
                w_state_nxt = S_A;
            end
        endcase
    end

    always_comb begin
        display = '0;
        case (r_state)
            S_A, S_B:      display = data_in;
            S_OP:          display = WIDTH'(op_in);
            S_CALC, S_RES: display = r_result;
            default:       display = '0;
        endcase
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign state_o      = r_state;
    assign result_valid = r_valid;
    assign error_o      = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with a behavioural ALU attached.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int unsigned W = 16;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  data_in;
    logic [1:0]    op_in;
    logic          enter;
    logic          undo;
    logic [W-1:0]  alu_result;
    logic          alu_error;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [1:0]    alu_op;
    logic [W-1:0]  display;
    logic [2:0]    state_o;
    logic          result_valid;
    logic          error_o;

    int n_checks;
    int n_fail;

    calc_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .op_in        (op_in),
        .enter        (enter),
        .undo         (undo),
        .alu_result   (alu_result),
        .alu_error    (alu_error),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .display      (display),
        .state_o      (state_o),
        .result_valid (result_valid),
        .error_o      (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: error is the carry (add) or borrow (sub) out of the top bit.
    always_comb begin
        {alu_error, alu_result} = '0;
        case (alu_op)
            OP_ADD:  {alu_error, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  {alu_error, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  {alu_error, alu_result} = {1'b0, alu_a & alu_b};
            default: {alu_error, alu_result} = {1'b0, alu_a | alu_b};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [W-1:0] d, input logic [1:0] op);
        data_in = d;
        op_in   = op;
        enter   = 1'b1;
        step(1);
        enter   = 1'b0;
        step(1);
    endtask

    task automatic press_undo();
        undo = 1'b1;
        step(1);
        undo = 1'b0;
        step(1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] exp_disp;
        logic         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        data_in  = '0;
        op_in    = '0;
        enter    = 1'b0;
        undo     = 1'b0;

        vecs[0] = '{a: 16'h0005, b: 16'h0003, op: 2'd0, exp_disp: 16'h0008, exp_err: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, op: 2'd0, exp_disp: 16'h0000, exp_err: 1'b1};
        vecs[2] = '{a: 16'h00F0, b: 16'h000F, op: 2'd3, exp_disp: 16'h00FF, exp_err: 1'b0};
        vecs[3] = '{a: 16'h0F0F, b: 16'h00FF, op: 2'd2, exp_disp: 16'h000F, exp_err: 1'b0};
        vecs[4] = '{a: 16'h0003, b: 16'h0005, op: 2'd1, exp_disp: 16'hFFFE, exp_err: 1'b1};
        vecs[5] = '{a: 16'h1234, b: 16'h0234, op: 2'd1, exp_disp: 16'h1000, exp_err: 1'b0};

        step(3);
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_alu_a", 32'(alu_a), 32'd0);
        check("reset_alu_b", 32'(alu_b), 32'd0);
        check("reset_alu_op", 32'(alu_op), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_error", 32'(error_o), 32'd0);
        check("reset_display", 32'(display), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Live display in S_A and S_OP.
        data_in = 16'h00A5;
        step(1);
        check("live_display_a", 32'(display), 32'h00A5);
        press_undo();
        check("undo_in_a", 32'(state_o), 32'd0);

        // Table: full A/B/op sequence, inspect the result, then undo back to S_A.
        for (int i = 0; i < 6; i++) begin
            press(vecs[i].a, 2'd0);
            check($sformatf("v%0d_state_b", i), 32'(state_o), 32'd1);
            press(vecs[i].b, 2'd0);
            op_in = vecs[i].op;
            step(1);
            check($sformatf("v%0d_op_display", i), 32'(display), 32'(vecs[i].op));
            press(16'h0000, vecs[i].op);
            check($sformatf("v%0d_state_res", i), 32'(state_o), 32'd4);
            check($sformatf("v%0d_display", i), 32'(display), 32'(vecs[i].exp_disp));
            check($sformatf("v%0d_error", i), 32'(error_o), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_valid", i), 32'(result_valid), 32'd1);
            press_undo();
            check($sformatf("v%0d_undo_state", i), 32'(state_o), 32'd0);
            check($sformatf("v%0d_undo_valid", i), 32'(result_valid), 32'd0);
            check($sformatf("v%0d_undo_error", i), 32'(error_o), 32'd0);
            check($sformatf("v%0d_undo_keeps_a", i), 32'(alu_a), 32'(vecs[i].a));
        end

        // Latency: op press edge -> S_CALC, next edge -> result_valid.
        press(16'h0005, 2'd0);
        press(16'h0003, 2'd0);
        op_in = 2'd0;
        enter = 1'b1;
        step(1);
        enter = 1'b0;
        check("lat_edge1_state", 32'(state_o), 32'd3);
        check("lat_edge1_valid", 32'(result_valid), 32'd0);
        step(1);
        check("lat_edge2_state", 32'(state_o), 32'd4);
        check("lat_edge2_valid", 32'(result_valid), 32'd1);
        check("lat_display", 32'(display), 32'h0008);
        check("lat_error", 32'(error_o), 32'd0);
        press_undo();

        // Error result: next press returns to S_A with error cleared.
        press(16'hFFFF, 2'd0);
        press(16'h0001, 2'd0);
        press(16'h0000, 2'd0);
        check("err_display", 32'(display), 32'h0000);
        check("err_flag", 32'(error_o), 32'd1);
        press(16'h1111, 2'd0);
        check("err_press_state", 32'(state_o), 32'd0);
        check("err_press_error", 32'(error_o), 32'd0);
        check("err_press_valid", 32'(result_valid), 32'd0);

        // Chaining the previous result into A.
        press(16'h00F0, 2'd0);
        press(16'h000F, 2'd0);
        press(16'h0000, 2'd3);
        check("chain_or_display", 32'(display), 32'h00FF);
        press(16'hAAAA, 2'd0);
        check("chain_state", 32'(state_o), 32'd1);
        check("chain_alu_a", 32'(alu_a), 32'h00FF);
        check("chain_valid", 32'(result_valid), 32'd0);
        press(16'h0F0F, 2'd0);
        press(16'h0000, 2'd2);
        check("chain_and_display", 32'(display), 32'h000F);
        press_undo();

        // Undo in S_OP, then simultaneous enter+undo in S_B.
        press(16'h0011, 2'd0);
        press(16'h0022, 2'd0);
        data_in = 16'h0099;
        press_undo();
        check("undo_op_state", 32'(state_o), 32'd1);
        check("undo_op_alu_b", 32'(alu_b), 32'h0022);
        data_in = 16'h0077;
        enter   = 1'b1;
        undo    = 1'b1;
        step(1);
        enter   = 1'b0;
        undo    = 1'b0;
        step(1);
        check("both_state", 32'(state_o), 32'd0);
        check("both_alu_b", 32'(alu_b), 32'h0022);
        check("both_alu_a", 32'(alu_a), 32'h0011);

        // Held enter produces a single transition.
        data_in = 16'h0042;
        enter   = 1'b1;
        step(10);
        check("held_state", 32'(state_o), 32'd1);
        check("held_alu_a", 32'(alu_a), 32'h0042);
        enter = 1'b0;
        step(1);
        press_undo();

        // Reset during S_CALC abandons the capture.
        press(16'h0100, 2'd0);
        press(16'h0200, 2'd0);
        op_in = 2'd0;
        enter = 1'b1;
        step(1);
        enter = 1'b0;
        check("rst_calc_pre_state", 32'(state_o), 32'd3);
        data_in = '0;
        op_in   = '0;
        rst_n   = 1'b0;
        #1;
        check("rst_calc_state", 32'(state_o), 32'd0);
        check("rst_calc_alu_a", 32'(alu_a), 32'd0);
        check("rst_calc_alu_b", 32'(alu_b), 32'd0);
        check("rst_calc_valid", 32'(result_valid), 32'd0);
        check("rst_calc_error", 32'(error_o), 32'd0);
        check("rst_calc_display", 32'(display), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("rst_calc_after_state", 32'(state_o), 32'd0);
        check("rst_calc_after_valid", 32'(result_valid), 32'd0);

        // Enter held across reset release stays silent until re-pressed.
        enter = 1'b1;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("held_rst_state", 32'(state_o), 32'd0);
        enter = 1'b0;
        step(1);
        press(16'h0033, 2'd0);
        check("held_rst_repress", 32'(state_o), 32'd1);
        check("held_rst_alu_a", 32'(alu_a), 32'h0033);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
